// File: rtl/phy_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// phy_rx_link_ctrl
// Link-level controller placed after phy_rx. It watches lane sync and the
// recovered 32-bit word stream, and walks the link through
// WAIT_ACTIVE -> TRAINING -> LINK_UP -> RECOVERY.
// Payload words are forwarded only while the link is up, and idle words are
// stripped. Every LINK_UP -> RECOVERY transition bumps a saturating debug
// counter.
//
// Ports (all in the clk_f domain):
//   clk_f          in   1   block clock, rising edge
//   reset          in   1   asynchronous active-high reset
//   active0        in   1   lane 0 synchronized
//   active1        in   1   lane 1 synchronized
//   data_in        in  32   recovered word from phy_rx
//   valid_in       in   1   data_in qualifier
//   data_out       out 32   forwarded payload word (1-cycle latency)
//   valid_out      out  1   data_out qualifier
//   link_up        out  1   high while in LINK_UP
//   link_state     out  2   current state (0 wait, 1 train, 2 up, 3 recovery)
//   retrain_count  out  8   saturating count of LINK_UP -> RECOVERY
// ---------------------------------------------------------------------------
module phy_rx_link_ctrl #(
  parameter logic [7:0] IDLE_BYTE   = 8'hBC,
  parameter int         TRAIN_COUNT = 4,
  parameter int         TIMEOUT     = 16
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic        active0,
  input  logic        active1,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        link_up,
  output logic [1:0]  link_state,
  output logic [7:0]  retrain_count
);

  typedef enum logic [1:0] {
    WAIT_ACTIVE = 2'd0,
    TRAINING    = 2'd1,
    LINK_UP     = 2'd2,
    RECOVERY    = 2'd3
  } state_t;

  localparam logic [31:0] IDLE_WORD  = {4{IDLE_BYTE}};
  localparam logic [8:0]  TRAIN_TGT  = 9'(TRAIN_COUNT);
  localparam logic [8:0]  TMO_TGT    = 9'(TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_train_cnt;
  logic [7:0]  r_tmo_cnt;
  logic [7:0]  r_retrain;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_link_up;
  logic [1:0]  r_link_state;

  state_t      w_next;
  logic        w_both;
  logic        w_idle_hit;
  logic [8:0]  w_train_inc;
  logic [8:0]  w_tmo_inc;
  logic        w_train_done;
  logic        w_tmo_done;
  logic [7:0]  w_train_nxt;
  logic [7:0]  w_tmo_nxt;
  logic [7:0]  w_retrain_nxt;
  logic [31:0] w_data_nxt;
  logic        w_valid_nxt;

  // A single active lane counts as "not both" everywhere.
  assign w_both       = active0 && active1;
  assign w_idle_hit   = valid_in && (data_in == IDLE_WORD);
  // Counters are widened by one bit so the +1 compare cannot wrap.
  assign w_train_inc  = {1'b0, r_train_cnt} + 9'd1;
  assign w_tmo_inc    = {1'b0, r_tmo_cnt} + 9'd1;
  assign w_train_done = w_idle_hit && (w_train_inc == TRAIN_TGT);
  assign w_tmo_done   = (w_tmo_inc == TMO_TGT);

  // State register plus all registered outputs and counters.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      r_state      <= WAIT_ACTIVE;
      r_train_cnt  <= 8'd0;
      r_tmo_cnt    <= 8'd0;
      r_retrain    <= 8'd0;
      r_data       <= 32'h0;
      r_valid      <= 1'b0;
      r_link_up    <= 1'b0;
      r_link_state <= 2'd0;
    end else begin
      r_state      <= w_next;
      r_train_cnt  <= w_train_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_retrain    <= w_retrain_nxt;
      r_data       <= w_data_nxt;
      r_valid      <= w_valid_nxt;
      r_link_up    <= (w_next == LINK_UP);
      r_link_state <= w_next;
    end
  end

  // Next-state logic. In RECOVERY, lanes coming back beats the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_ACTIVE: if (w_both) w_next = TRAINING;
      TRAINING: begin
        if (!w_both)           w_next = WAIT_ACTIVE;
        else if (w_train_done) w_next = LINK_UP;
      end
      LINK_UP:  if (!w_both) w_next = RECOVERY;
      RECOVERY: begin
        if (w_both)          w_next = TRAINING;
        else if (w_tmo_done) w_next = WAIT_ACTIVE;
      end
      default:  w_next = WAIT_ACTIVE;
    endcase
  end

  // Counter and datapath next values. data_out only ever changes when a
  // payload word is accepted in LINK_UP; otherwise it holds.
  always_comb begin
    w_train_nxt   = 8'd0;
    w_tmo_nxt     = 8'd0;
    w_retrain_nxt = r_retrain;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    case (r_state)
      TRAINING: begin
        if (!w_both)           w_train_nxt = 8'd0;
        else if (w_train_done) w_train_nxt = 8'd0;
        else if (w_idle_hit)   w_train_nxt = w_train_inc[7:0];
        else if (valid_in)     w_train_nxt = 8'd0;
        else                   w_train_nxt = r_train_cnt;
      end
      LINK_UP: begin
        if (!w_both) begin
          // The word sampled on the drop cycle is discarded.
          if (r_retrain != 8'hFF) w_retrain_nxt = r_retrain + 8'd1;
        end else if (valid_in && !w_idle_hit) begin
          w_data_nxt  = data_in;
          w_valid_nxt = 1'b1;
        end
      end
      RECOVERY: begin
        if (w_both || w_tmo_done) w_tmo_nxt = 8'd0;
        else                      w_tmo_nxt = w_tmo_inc[7:0];
      end
      default: begin
        w_train_nxt = 8'd0;
        w_tmo_nxt   = 8'd0;
      end
    endcase
  end

  assign data_out      = r_data;
  assign valid_out     = r_valid;
  assign link_up       = r_link_up;
  assign link_state    = r_link_state;
  assign retrain_count = r_retrain;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phy_rx_link_ctrl
// Directed bench for phy_rx_link_ctrl. Words that should be forwarded are
// pushed onto an expected queue as they are driven; a negedge monitor pops
// and compares every time valid_out is seen high. State, link_up and the
// retrain counter are checked directly against hand-computed values.
// ---------------------------------------------------------------------------
module tb_phy_rx_link_ctrl;

  localparam logic [31:0] IDLE = 32'hBCBCBCBC;

  logic        clk_f = 1'b0;
  logic        reset;
  logic        active0;
  logic        active1;
  logic [31:0] data_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        link_up;
  logic [1:0]  link_state;
  logic [7:0]  retrain_count;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] expQ[$];
  logic [31:0] monExp;

  phy_rx_link_ctrl #(
    .IDLE_BYTE   (8'hBC),
    .TRAIN_COUNT (4),
    .TIMEOUT     (16)
  ) dut (
    .clk_f         (clk_f),
    .reset         (reset),
    .active0       (active0),
    .active1       (active1),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .link_up       (link_up),
    .link_state    (link_state),
    .retrain_count (retrain_count)
  );

  // 10 ns clock.
  always #5 clk_f = ~clk_f;

  // One comparison: counts it, and reports it if it does not match.
  task automatic compareVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, optionally record the word as expected
  // output, then step to just after the next rising edge.
  task automatic applyStimulus(input logic a0, input logic a1,
                               input logic v, input logic [31:0] d,
                               input bit fwd);
    active0  = a0;
    active1  = a1;
    valid_in = v;
    data_in  = d;
    if (fwd) expQ.push_back(d);
    @(posedge clk_f);
    #1;
  endtask

  // Check the link status outputs against hand-computed values.
  task automatic checkOutput(input string name, input logic [1:0] st,
                             input logic lu, input logic [7:0] rc);
    compareVal({name, ".state"},   32'(link_state),    32'(st));
    compareVal({name, ".link_up"}, 32'(link_up),       32'(lu));
    compareVal({name, ".retrain"}, 32'(retrain_count), 32'(rc));
  endtask

  // Scoreboard monitor: every valid_out cycle must match the oldest
  // expected word, and a valid_out with nothing expected is an error.
  always @(negedge clk_f) begin
    if (!reset && valid_out === 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_valid: got data %h expected no output", data_out);
      end else begin
        monExp = expQ.pop_front();
        compareVal("fwd_data", data_out, monExp);
      end
    end
  end

  // Safety net so the bench always ends.
  initial begin
    #1000000;
    compared++;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Main directed sequence.
  initial begin
    reset    = 1'b1;
    active0  = 1'b1;
    active1  = 1'b1;
    valid_in = 1'b0;
    data_in  = 32'h0;

    // Reset held for 3 cycles with both lanes up.
    repeat (3) @(posedge clk_f);
    #1;
    checkOutput("reset", 2'd0, 1'b0, 8'd0);
    compareVal("reset.valid_out", 32'(valid_out), 32'd0);
    compareVal("reset.data_out", data_out, 32'h0);
    reset = 1'b0;
    checkOutput("post_reset", 2'd0, 1'b0, 8'd0);
    applyStimulus(1, 1, 0, 32'h0, 0);
    checkOutput("wait_to_train", 2'd1, 1'b0, 8'd0);

    // Four idle words bring the link up on the fourth edge.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 1, IDLE, 0);
      if (i < 3) checkOutput("train_partial", 2'd1, 1'b0, 8'd0);
    end
    checkOutput("train_up", 2'd2, 1'b1, 8'd0);
    applyStimulus(1, 1, 1, 32'h12345678, 1);
    applyStimulus(1, 1, 0, 32'h0, 0);
    compareVal("fwd_valid_drop", 32'(valid_out), 32'd0);
    compareVal("fwd_data_hold", data_out, 32'h12345678);

    // Idle words around a payload word are stripped.
    applyStimulus(1, 1, 1, IDLE, 0);
    applyStimulus(1, 1, 1, 32'hA5A5A5A5, 1);
    applyStimulus(1, 1, 1, IDLE, 0);
    compareVal("idle_strip_valid", 32'(valid_out), 32'd0);
    compareVal("idle_strip_hold", data_out, 32'hA5A5A5A5);

    // Lane 1 drops for 5 cycles; the word on the drop cycle is lost.
    applyStimulus(1, 0, 1, 32'h11111111, 0);
    checkOutput("drop_a1", 2'd3, 1'b0, 8'd1);
    compareVal("drop_a1.valid_out", 32'(valid_out), 32'd0);
    repeat (4) applyStimulus(1, 0, 0, 32'h0, 0);
    checkOutput("recov_hold", 2'd3, 1'b0, 8'd1);
    applyStimulus(1, 1, 0, 32'h0, 0);
    checkOutput("recov_to_train", 2'd1, 1'b0, 8'd1);

    // A non-idle word resets training; an invalid gap holds the count.
    applyStimulus(1, 1, 1, IDLE, 0);
    applyStimulus(1, 1, 1, IDLE, 0);
    applyStimulus(1, 1, 1, 32'hDEADBEEF, 0);
    applyStimulus(1, 1, 1, IDLE, 0);
    applyStimulus(1, 1, 0, IDLE, 0);
    applyStimulus(1, 1, 1, IDLE, 0);
    applyStimulus(1, 1, 1, IDLE, 0);
    checkOutput("train_hold", 2'd1, 1'b0, 8'd1);
    applyStimulus(1, 1, 1, IDLE, 0);
    checkOutput("train_reup", 2'd2, 1'b1, 8'd1);

    // Lanes return on the very cycle the timeout would expire.
    applyStimulus(0, 1, 0, 32'h0, 0);
    checkOutput("drop_a0", 2'd3, 1'b0, 8'd2);
    repeat (15) applyStimulus(0, 1, 0, 32'h0, 0);
    checkOutput("tmo_edge", 2'd3, 1'b0, 8'd2);
    applyStimulus(1, 1, 0, 32'h0, 0);
    checkOutput("both_beats_tmo", 2'd1, 1'b0, 8'd2);
    repeat (4) applyStimulus(1, 1, 1, IDLE, 0);
    checkOutput("retrain_up", 2'd2, 1'b1, 8'd2);

    // Lane 0 lost for good: 16 cycles in RECOVERY, then back to wait.
    applyStimulus(0, 1, 0, 32'h0, 0);
    checkOutput("perm_drop", 2'd3, 1'b0, 8'd3);
    repeat (15) applyStimulus(0, 1, 0, 32'h0, 0);
    checkOutput("tmo_last", 2'd3, 1'b0, 8'd3);
    applyStimulus(0, 1, 0, 32'h0, 0);
    checkOutput("tmo_expire", 2'd0, 1'b0, 8'd3);
    applyStimulus(0, 1, 1, IDLE, 0);
    checkOutput("xor_wait", 2'd0, 1'b0, 8'd3);

    // 260 more link drops push the retrain counter into saturation.
    for (int k = 0; k < 260; k++) begin
      applyStimulus(1, 1, 0, 32'h0, 0);
      repeat (4) applyStimulus(1, 1, 1, IDLE, 0);
      applyStimulus(0, 1, 0, 32'h0, 0);
      if (k == 99) checkOutput("sat_mid", 2'd3, 1'b0, 8'd103);
    end
    checkOutput("sat_ff", 2'd3, 1'b0, 8'hFF);

    // Reset while a payload word is being presented in LINK_UP.
    applyStimulus(1, 1, 0, 32'h0, 0);
    repeat (4) applyStimulus(1, 1, 1, IDLE, 0);
    checkOutput("pre_reset_up", 2'd2, 1'b1, 8'hFF);
    valid_in = 1'b1;
    data_in  = 32'hCAFEF00D;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 2'd0, 1'b0, 8'd0);
    compareVal("async_reset.valid_out", 32'(valid_out), 32'd0);
    compareVal("async_reset.data_out", data_out, 32'h0);
    @(posedge clk_f);
    #1;
    reset = 1'b0;
    applyStimulus(1, 1, 0, 32'h0, 0);
    checkOutput("after_reset", 2'd1, 1'b0, 8'd0);
    repeat (2) applyStimulus(1, 1, 0, 32'h0, 0);
    compareVal("queue_empty", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
